// File: rtl/picorv32_mem_pkg.sv
// rtl/picorv32_mem_pkg.sv - shared types for the two-requester PicoRV32 memory arbiter
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  localparam mem_req_t MEM_REQ_IDLE = '{
    valid: 1'b0,
    instr: 1'b0,
    addr:  32'h0,
    wdata: 32'h0,
    wstrb: WSTRB_READ
  };

endpackage

// File: rtl/mem_wait_watchdog.sv
// rtl/mem_wait_watchdog.sv - saturating stall counter with sticky timeout flag for a native memory port
module mem_wait_watchdog #(
  parameter int TIMEOUT = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic ready,
  output logic timeout_err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [7:0] cnt;

  // Counts consecutive stall cycles; any cycle without a pending stall restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 8'd0;
      timeout_err <= 1'b0;
    end else if (valid && !ready) begin
      if (cnt == TIMEOUT_CNT) begin
        timeout_err <= 1'b1;
      end
      if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= 8'd0;
    end
  end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - round-robin arbiter sharing one PicoRV32 native memory port between two requesters
module picorv32_mem_arbiter
  import picorv32_mem_pkg::*;
#(
  parameter int TIMEOUT    = 31,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_t state, state_next;
  logic       last, last_next;
  mem_req_t   req0, req1, sel;

  assign req0 = '{valid: m0_valid, instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1 = '{valid: m1_valid, instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      last  <= ~RESET_PRIO;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  always_comb begin
    state_next = state;
    last_next  = last;
    sel        = MEM_REQ_IDLE;
    m0_ready   = 1'b0;
    m0_rdata   = 32'h0;
    m1_ready   = 1'b0;
    m1_rdata   = 32'h0;
    grant      = 2'b00;
    case (state)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (m0_valid && m1_valid) begin
          state_next = last ? OWN0 : OWN1;
        end else if (m0_valid) begin
          state_next = OWN0;
        end else if (m1_valid) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        sel      = req0;
        grant    = 2'b01;
        m0_ready = s_ready & m0_valid;
        m0_rdata = s_rdata;
        if (!m0_valid) begin
          state_next = IDLE;
        end else if (s_ready) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end
      end
      OWN1: begin
        sel      = req1;
        grant    = 2'b10;
        m1_ready = s_ready & m1_valid;
        m1_rdata = s_rdata;
        if (!m1_valid) begin
          state_next = IDLE;
        end else if (s_ready) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_valid = sel.valid;
  assign s_instr = sel.instr;
  assign s_addr  = sel.addr;
  assign s_wdata = sel.wdata;
  assign s_wstrb = sel.wstrb;

  mem_wait_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .valid      (s_valid),
    .ready      (s_ready),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - directed self-checking bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  picorv32_mem_arbiter #(
    .TIMEOUT   (4),
    .RESET_PRIO(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_instr   (m0_instr),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_instr   (m1_instr),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_instr    (s_instr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle with the owner's request already driven; returns in the IDLE cycle after completion.
  task automatic do_xfer(input int owner, input int stall, input logic instr, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata, input logic [31:0] rdata);
    logic [1:0] g;
    g = (owner == 0) ? 2'b01 : 2'b10;
    tick();
    repeat (stall) begin
      check("wait_grant", 32'(grant), 32'(g));
      check("wait_ready", 32'({m1_ready, m0_ready}), 32'h0);
      tick();
    end
    s_ready = 1'b1;
    s_rdata = rdata;
    #1;
    check("grant", 32'(grant), 32'(g));
    check("s_valid", 32'(s_valid), 32'h1);
    check("s_instr", 32'(s_instr), 32'(instr));
    check("s_addr", s_addr, addr);
    check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
    check("s_wdata", s_wdata, wdata);
    check("ready", 32'({m1_ready, m0_ready}), 32'(g));
    check("owner_rdata", (owner == 0) ? m0_rdata : m1_rdata, rdata);
    check("other_rdata", (owner == 0) ? m1_rdata : m0_rdata, 32'h0);
    tick();
    s_ready = 1'b0;
    s_rdata = 32'h0;
    #1;
    check("idle_grant", 32'(grant), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset    = 1'b1;
    m0_valid = 1'b1; m0_instr = 1'b0; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h20; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    s_ready  = 1'b1;
    s_rdata  = 32'hA5A5A5A5;
    #3;
    check("rst_s_valid", 32'(s_valid), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    check("rst_addr", s_addr, 32'h0);
    check("rst_timeout", 32'(timeout_err), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
    reset = 1'b0;

    // m0 instruction read alone, ready on the third s_valid cycle
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    #1;
    check("t1_req_grant", 32'(grant), 32'h0);
    check("t1_req_s_valid", 32'(s_valid), 32'h0);
    do_xfer(0, 2, 1'b1, 32'h100, 4'h0, 32'h0, 32'hDEADBEEF);
    m0_valid = 1'b0; m0_instr = 1'b0;

    // both request from reset: strict alternation starting with m0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0; m0_wdata = 32'h0;
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wstrb = 4'hF; m1_wdata = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) do_xfer(0, 1, 1'b0, 32'h200, 4'h0, 32'h0, 32'h1000 + 32'(i));
      else            do_xfer(1, 1, 1'b0, 32'h300, 4'hF, 32'hCAFE0001, 32'h1000 + 32'(i));
    end

    // m1 write arrives while m0 streams reads; m1 served after one m0 transfer
    m1_valid = 1'b0;
    m0_addr  = 32'h500;
    tick();
    m1_valid = 1'b1; m1_addr = 32'h400; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    check("t3_grant_m0", 32'(grant), 32'h1);
    s_ready = 1'b1;
    #1;
    check("t3_m0_ready", 32'(m0_ready), 32'h1);
    tick();
    s_ready = 1'b0;
    do_xfer(1, 0, 1'b0, 32'h400, 4'b0011, 32'h12345678, 32'h0);
    m1_valid = 1'b0;
    do_xfer(0, 0, 1'b0, 32'h500, 4'h0, 32'h0, 32'h55);
    m0_valid = 1'b0;

    // watchdog with TIMEOUT=4: flag visible after five stalled s_valid cycles, then sticky
    m0_valid = 1'b1; m0_addr = 32'h600;
    tick();
    for (int k = 1; k <= 5; k++) begin
      check("t4_err_before", 32'(timeout_err), 32'h0);
      tick();
    end
    check("t4_err_set", 32'(timeout_err), 32'h1);
    check("t4_still_owned", 32'(grant), 32'h1);
    s_ready = 1'b1;
    #1;
    check("t4_m0_ready", 32'(m0_ready), 32'h1);
    tick();
    s_ready = 1'b0; m0_valid = 1'b0;
    #1;
    check("t4_err_sticky", 32'(timeout_err), 32'h1);
    check("t4_idle", 32'(grant), 32'h0);

    // reset in the middle of an m1 transfer
    m1_valid = 1'b1; m1_addr = 32'h700; m1_wstrb = 4'h0; m1_wdata = 32'h0;
    tick();
    check("t5_grant_m1", 32'(grant), 32'h2);
    s_ready = 1'b1;
    reset   = 1'b1;
    #1;
    check("t5_rst_s_valid", 32'(s_valid), 32'h0);
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_m1_ready", 32'(m1_ready), 32'h0);
    check("t5_rst_err", 32'(timeout_err), 32'h0);
    m0_valid = 1'b1; m0_addr = 32'h800;
    tick();
    tick();
    check("t5_hold_grant", 32'(grant), 32'h0);
    reset = 1'b0; s_ready = 1'b0;
    tick();
    check("t5_prio_grant", 32'(grant), 32'h1);

    // m0 abandons its request before ready; m1 gets the next grant
    check("t6_s_valid", 32'(s_valid), 32'h1);
    tick();
    m0_valid = 1'b0; s_ready = 1'b1;
    #1;
    check("t6_abort_s_valid", 32'(s_valid), 32'h0);
    check("t6_abort_ready", 32'(m0_ready), 32'h0);
    tick();
    s_ready = 1'b0;
    #1;
    check("t6_abort_idle", 32'(grant), 32'h0);
    do_xfer(1, 0, 1'b0, 32'h700, 4'h0, 32'h0, 32'h77);
    m0_valid = 1'b1;
    tick();
    check("t6_tie_after_m1", 32'(grant), 32'h1);
    m0_valid = 1'b0; m1_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/picorv32_mem_arbiter.md
Name: picorv32_mem_arbiter

Overview:
Two-requester arbiter sharing one PicoRV32-native memory port (valid/ready/addr/wdata/wstrb/rdata/instr) between requesters m0 and m1. Typical pairings are two cores, or a core and a debug/DMA agent, sitting in front of a single memory model or formal memory check.
Fairness is round-robin. Each transfer is held atomically until the slave's single-cycle ready. A bounded-wait watchdog flags slaves that stall too long.

Parameters:
TIMEOUT, 31, max cycles s_valid may stay high without s_ready before timeout_err sets; legal range 1..255.
RESET_PRIO, 0, requester favoured on the first tie after reset (0 or 1).

Ports:
clk  input  1  clock, all state rising-edge
reset  input  1  asynchronous, active-high; clears all state
m0_valid  input  1  requester 0 transfer request, held until m0_ready
m0_instr  input  1  requester 0 instruction-fetch qualifier
m0_addr  input  32  requester 0 byte address
m0_wdata  input  32  requester 0 write data
m0_wstrb  input  4  requester 0 byte strobes; 0 = read
m0_ready  output  1  requester 0 completion pulse
m0_rdata  output  32  requester 0 read data, valid with m0_ready
m1_*  same set as m0_*, for requester 1
s_valid  output  1  shared port request
s_instr  output  1  shared port instr qualifier
s_addr  output  32  shared port address
s_wdata  output  32  shared port write data
s_wstrb  output  4  shared port strobes
s_ready  input  1  shared port completion
s_rdata  input  32  shared port read data
grant  output  2  one-hot current owner; 00 when idle
timeout_err  output  1  sticky watchdog flag

Behaviour:
- State machine: IDLE, OWN0, OWN1. Registered state.
- Reset values: state=IDLE, grant=00, last=~RESET_PRIO, wait counter=0, timeout_err=0.
- During reset, all outputs are 0.

Arbitration in IDLE:
- If exactly one mX_valid is high, go to OWNX next cycle.
- If both are high, grant the requester that is not `last`.
- Latency: request seen at edge t gives s_valid high during cycle t+1. Arbitration adds no further latency.

OWNX state:
- s_valid = mX_valid.
- s_instr, s_addr, s_wdata and s_wstrb are combinationally muxed from mX.
- mX_ready = s_ready & s_valid (combinational). mX_rdata = s_rdata.
- The non-owner sees ready=0 and rdata=0.

Completion:
- s_valid & s_ready: next state IDLE, last<=X, counter<=0.
- Minimum turnaround is therefore 1 idle cycle between transfers.

Abort:
- If the owner drops mX_valid before ready (protocol violation), return to IDLE next cycle.
- No ready is issued. `last` is not updated.
- s_ready arriving while s_valid=0 is ignored.

Watchdog (8-bit counter):
- Increments on each cycle with s_valid & !s_ready. Saturates at 255.
- When counter == TIMEOUT and the stall continues, timeout_err<=1.
- timeout_err is sticky until reset. The arbiter keeps waiting; it never forces completion.

Other rules:
- Reset asserted mid-transfer: immediate return to IDLE with s_valid=0. No partial ready is delivered.
- Fairness bound: a requesting master waits at most one full transfer of the other master.
- The grant output mirrors state: OWN0 gives 01, OWN1 gives 10.

Decomposition:
- Shared package `picorv32_mem_pkg`:
  - state enum {IDLE, OWN0, OWN1}
  - memory request struct {valid, instr, addr[31:0], wdata[31:0], wstrb[3:0]}
  - WSTRB_READ constant = 4'b0000
- Sub-module `mem_wait_watchdog`: counter plus sticky flag, parameterised by TIMEOUT. It is reusable on any native port.
- The mux/FSM stays in the top module.

Test Plan:
- m0 read alone, addr 0x100, s_ready at 3rd cycle of s_valid, s_rdata=0xDEADBEEF -> grant=01 one cycle after request; m0_ready pulses once with m0_rdata=0xDEADBEEF; m1_ready stays 0; back to IDLE.
- m0 and m1 both request from reset with RESET_PRIO=0, each s_ready after 1 cycle -> order m0, m1, m0, m1; s_addr/s_wstrb match the owner on every s_valid cycle.
- m1 write 0x12345678, wstrb=4'b0011, while m0 streams back-to-back reads -> m1 is served after at most one m0 transfer; s_wdata=0x12345678 and s_wstrb=0011 while grant=10.
- s_ready withheld with TIMEOUT=4 -> timeout_err rises after s_valid has been high 5 consecutive cycles; stays 1 after a later s_ready completes the transfer.
- reset asserted mid-OWN1 -> same-cycle s_valid=0, grant=00, no m1_ready; after release, arbitration restarts with RESET_PRIO preference.
- m0 drops m0_valid in OWN0 before s_ready -> IDLE next cycle; no m0_ready; with m1 pending the next grant goes to m1 (last unchanged).
